// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with valid/ready handshake and iterative mul/div/mod
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [7:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic                 err,
  output logic                 div0
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [7:0]       op_r;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;

  logic [RW-1:0]        sc_result;
  logic                 sc_err;
  logic                 sc_div0;
  logic                 iter_start;
  logic [RW-1:0]        a_ext;
  logic [RW-1:0]        b_ext;
  logic signed [RW-1:0] a_sext;

  // Single-cycle results, divide-by-zero and illegal-opcode detection, straight from the inputs
  always_comb begin
    sc_result  = '0;
    sc_err     = 1'b0;
    sc_div0    = 1'b0;
    iter_start = 1'b0;
    a_ext      = {{WIDTH{1'b0}}, a};
    b_ext      = {{WIDTH{1'b0}}, b};
    a_sext     = $signed({{WIDTH{a[WIDTH-1]}}, a});
    case (opcode)
      8'h00: sc_result = a_ext + b_ext;
      8'h01: sc_result = a_ext - b_ext;
      8'h02: iter_start = 1'b1;
      8'h03: begin
        if (b == '0) begin
          sc_result = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
          sc_div0   = 1'b1;
        end else begin
          iter_start = 1'b1;
        end
      end
      8'h04: begin
        if (b == '0) begin
          sc_result = a_ext;
          sc_div0   = 1'b1;
        end else begin
          iter_start = 1'b1;
        end
      end
      8'h06: sc_result = a_ext & b_ext;
      8'h07: sc_result = a_ext | b_ext;
      8'h08: sc_result = a_ext ^ b_ext;
      8'h09: sc_result = {a, b};
      8'h0A, 8'h0C: sc_result = a_ext << b;
      8'h0B: sc_result = a_ext >> b;
      8'h0D: sc_result = $unsigned(a_sext >>> b);
      8'h0E: sc_result = {{(RW-1){1'b0}}, (a >= b)};
      8'h0F: sc_result = {{(RW-1){1'b0}}, (a == b)};
      default: sc_err = 1'b1;
    endcase
  end

  logic [RW-1:0]    acc_nx;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] rem_nx;
  logic [RW-1:0]    iter_result;

  // One shift-add multiply step and one restoring-division step per BUSY cycle
  always_comb begin
    acc_nx = mplier[0] ? (acc + mcand) : acc;
    trial  = {rem, quo[WIDTH-1]};
    if (trial >= {1'b0, divisor}) begin
      rem_nx = trial[WIDTH-1:0] - divisor;
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
    case (op_r)
      8'h02:   iter_result = acc_nx;
      8'h03:   iter_result = {{WIDTH{1'b0}}, quo_nx};
      default: iter_result = {{WIDTH{1'b0}}, rem_nx};
    endcase
  end

  // Control FSM with registered handshake, result and flag outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
      div0      <= 1'b0;
      op_r      <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      quo       <= '0;
      rem       <= '0;
      divisor   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r     <= opcode;
            in_ready <= 1'b0;
            err      <= sc_err;
            div0     <= sc_div0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, a};
            mplier   <= b;
            quo      <= a;
            rem      <= '0;
            divisor  <= b;
            if (iter_start) begin
              state <= BUSY;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= sc_result;
              zero      <= (sc_result == '0);
            end
          end
        end
        BUSY: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          quo    <= quo_nx;
          rem    <= rem_nx;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= iter_result;
            zero      <= (iter_result == '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [7:0]    opcode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic          zero;
  logic          err;
  logic          div0;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .err(err), .div0(div0)
  );

  always #5 clk = ~clk;

  // Behavioural reference: plain integer arithmetic over a 16-bit result space
  function automatic void model(input int op, input int av, input int bv,
                                output int r, output bit e, output bit d, output int lat);
    int sa;
    r = 0; e = 0; d = 0; lat = 1;
    case (op)
      'h00: r = av + bv;
      'h01: r = (av - bv) & 'hFFFF;
      'h02: begin r = av * bv; lat = W + 1; end
      'h03: if (bv == 0) begin r = 'h00FF; d = 1; end else begin r = av / bv; lat = W + 1; end
      'h04: if (bv == 0) begin r = av; d = 1; end else begin r = av % bv; lat = W + 1; end
      'h06: r = av & bv;
      'h07: r = av | bv;
      'h08: r = av ^ bv;
      'h09: r = av * 256 + bv;
      'h0A, 'h0C: r = (bv >= 16) ? 0 : ((av << bv) & 'hFFFF);
      'h0B: r = (bv >= 16) ? 0 : (av >> bv);
      'h0D: begin
        sa = (av >= 128) ? av - 256 : av;
        if (bv >= 16) r = (sa < 0) ? 'hFFFF : 0;
        else r = (sa >>> bv) & 'hFFFF;
      end
      'h0E: r = (av >= bv) ? 1 : 0;
      'h0F: r = (av == bv) ? 1 : 0;
      default: begin r = 0; e = 1; end
    endcase
  endfunction

  // Drives one operation, waits for the result, records what was seen, completes the handshake
  task automatic run_op(input logic [7:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output logic [2*W-1:0] r, output logic z, output logic e, output logic d,
                        output int lat, output bit busy_ready_low);
    opcode = op; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); opcode = 8'($urandom);
    lat = 1;
    busy_ready_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ready_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    r = result; z = zero; e = err; d = div0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", zero); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL reset_div0 got %b want 0", div0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Runs one op and compares every observable against the model
  task automatic check_op(input string name, input logic [7:0] op, input logic [W-1:0] av,
                          input logic [W-1:0] bv);
    logic [2*W-1:0] r; logic z, e, d; int lat; bit rl;
    int er, el; bit ee, ed;
    run_op(op, av, bv, r, z, e, d, lat, rl);
    model(int'(op), int'(av), int'(bv), er, ee, ed, el);
    checks++; if (r !== 16'(er)) begin errors++; $display("FAIL %s_result op=%h a=%h b=%h got %h want %h", name, op, av, bv, r, 16'(er)); end
    checks++; if (z !== (er == 0)) begin errors++; $display("FAIL %s_zero op=%h got %b want %b", name, op, z, (er == 0)); end
    checks++; if (e !== ee) begin errors++; $display("FAIL %s_err op=%h got %b want %b", name, op, e, ee); end
    checks++; if (d !== ed) begin errors++; $display("FAIL %s_div0 op=%h got %b want %b", name, op, d, ed); end
    checks++; if (lat != el) begin errors++; $display("FAIL %s_latency op=%h got %0d want %0d", name, op, lat, el); end
    checks++; if (!rl) begin errors++; $display("FAIL %s_in_ready_busy op=%h got 1 want 0", name, op); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready_after got %b want 1", name, in_ready); end
  endtask

  task automatic test_single_cycle();
    check_op("add", 8'h00, 8'hFF, 8'h01);
    check_op("asr", 8'h0D, 8'h80, 8'd3);
    check_op("lsr", 8'h0B, 8'h80, 8'd3);
    check_op("lsl16", 8'h0A, 8'h01, 8'd16);
    check_op("asr_big", 8'h0D, 8'h91, 8'd200);
    check_op("illegal", 8'h3F, 8'h12, 8'h34);
    check_op("pow", 8'h05, 8'h03, 8'h02);
    check_op("sub_wrap", 8'h01, 8'h00, 8'h01);
  endtask

  task automatic test_iterative();
    check_op("mul", 8'h02, 8'hFF, 8'hFF);
    check_op("div", 8'h03, 8'd200, 8'd7);
    check_op("mod", 8'h04, 8'd200, 8'd7);
    check_op("div0", 8'h03, 8'd5, 8'd0);
    check_op("mod0", 8'h04, 8'd9, 8'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [7:0] op; logic [W-1:0] av, bv;
      op = (i % 7 == 6) ? 8'($urandom) : 8'($urandom_range(0, 15));
      av = W'($urandom);
      bv = (i % 5 == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      if (op == 8'h02 && bv == '0) bv = 8'd1;
      check_op("rand", op, av, bv);
    end
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] held_r; logic held_z, held_e, held_d;
    int n;
    opcode = 8'h00; a = 8'h10; b = 8'h20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (out_valid !== 1'b1 || result !== 16'h0030) begin errors++; $display("FAIL bp_first got valid=%b result=%h want 1/0030", out_valid, result); end
    held_r = result; held_z = zero; held_e = err; held_d = div0;
    in_valid = 1'b1; opcode = 8'h02; a = 8'h33; b = 8'h44;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== held_r || zero !== held_z ||
          err !== held_e || div0 !== held_d) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b rdy=%b r=%h want v=1 rdy=0 r=%h", i, out_valid, in_ready, result, held_r);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got rdy=%b v=%b want 1/0", in_ready, out_valid); end
    opcode = 8'h3F; a = 8'h55; b = 8'h66; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || err !== 1'b1 || result !== '0 || zero !== 1'b1) begin
      errors++; $display("FAIL bp_illegal got v=%b err=%b r=%h z=%b want 1/1/0000/1", out_valid, err, result, zero);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit seen;
    opcode = 8'h02; a = 8'hAB; b = 8'hCD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL abort_busy got v=%b rdy=%b want 0/0", out_valid, in_ready); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || zero !== 1'b0 ||
        err !== 1'b0 || div0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset got v=%b rdy=%b r=%h z=%b e=%b d=%b want 0/1/0000/0/0/0", out_valid, in_ready, result, zero, err, div0);
    end
    seen = 1'b0;
    out_ready = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    checks++; if (seen) begin errors++; $display("FAIL abort_no_result got out_valid=1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_iterative();
    test_backpressure();
    test_random();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
